// File: rtl/ama_riscv_defines.sv
// Shared constants for the AMA RISC-V core: NOP encoding, immediate
// selector codes and register-file geometry.
package ama_riscv_defines;

  localparam logic [31:0] NOP = 32'h0000_0013;

  localparam int REG_NUM = 32;
  localparam int REG_AW  = 5;

  localparam logic [2:0] IG_I = 3'd1;
  localparam logic [2:0] IG_S = 3'd2;
  localparam logic [2:0] IG_B = 3'd3;
  localparam logic [2:0] IG_J = 3'd4;
  localparam logic [2:0] IG_U = 3'd5;

endpackage

// File: rtl/ama_riscv_reg_file.sv
// Integer register file: x1..x31 storage, x0 hardwired to zero,
// two combinational read ports with write-through bypass.
module ama_riscv_reg_file
  import ama_riscv_defines::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [REG_AW-1:0] addr_d,
  input  logic [31:0]       data_d,
  input  logic [REG_AW-1:0] addr_a,
  input  logic [REG_AW-1:0] addr_b,
  output logic [31:0]       data_a,
  output logic [31:0]       data_b
);

  logic [31:0] r_regs [1:REG_NUM-1];
  logic        w_wr;

  assign w_wr = we && (addr_d != '0);

  // contents are not cleared; reset only blocks writes
  always_ff @(posedge clk) begin
    if (!rst && w_wr) begin
      r_regs[addr_d] <= data_d;
    end
  end

  function automatic logic [31:0] rd_port(
    input logic [REG_AW-1:0] a
  );
    if (a == '0)
      return 32'h0;
    else if (w_wr && (a == addr_d))
      return data_d;
    else
      return r_regs[a];
  endfunction

  assign data_a = rd_port(addr_a);
  assign data_b = rd_port(addr_b);

endmodule

// File: rtl/ama_riscv_id_stage.sv
// Decode stage: register-file read, immediate generation and the
// ID/EX pipeline register with stall/clear control.
module ama_riscv_id_stage
  import ama_riscv_defines::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst_id,
  input  logic [31:0] pc_id,
  input  logic [2:0]  ig_sel,
  input  logic        reg_we_id,
  input  logic        stall_id,
  input  logic        clear_ex,
  input  logic        reg_we_wb,
  input  logic [4:0]  rd_wb,
  input  logic [31:0] data_wb,
  output logic [31:0] inst_ex,
  output logic [31:0] pc_ex,
  output logic [31:0] rs1_data_ex,
  output logic [31:0] rs2_data_ex,
  output logic [31:0] imm_ex,
  output logic [4:0]  rd_ex,
  output logic        reg_we_ex
);

  logic [31:0] w_rs1_data;
  logic [31:0] w_rs2_data;
  logic [31:0] w_imm;
  logic [4:0]  w_rd;
  logic        w_we;

  ama_riscv_reg_file u_rf (
    .clk    (clk),
    .rst    (rst),
    .we     (reg_we_wb),
    .addr_d (rd_wb),
    .data_d (data_wb),
    .addr_a (inst_id[19:15]),
    .addr_b (inst_id[24:20]),
    .data_a (w_rs1_data),
    .data_b (w_rs2_data)
  );

  always_comb begin
    w_imm = 32'h0;
    case (ig_sel)
      IG_I: w_imm = {{20{inst_id[31]}}, inst_id[31:20]};
      IG_S: w_imm = {{20{inst_id[31]}}, inst_id[31:25],
                     inst_id[11:7]};
      IG_B: w_imm = {{19{inst_id[31]}}, inst_id[31], inst_id[7],
                     inst_id[30:25], inst_id[11:8], 1'b0};
      IG_J: w_imm = {{11{inst_id[31]}}, inst_id[31],
                     inst_id[19:12], inst_id[20],
                     inst_id[30:21], 1'b0};
      IG_U: w_imm = {inst_id[31:12], 12'h000};
      default: w_imm = 32'h0;
    endcase
  end

  assign w_rd = inst_id[11:7];
  assign w_we = reg_we_id && (w_rd != 5'd0);

  always_ff @(posedge clk) begin
    if (rst || clear_ex) begin
      inst_ex     <= NOP;
      pc_ex       <= 32'h0;
      rs1_data_ex <= 32'h0;
      rs2_data_ex <= 32'h0;
      imm_ex      <= 32'h0;
      rd_ex       <= 5'd0;
      reg_we_ex   <= 1'b0;
    end else if (!stall_id) begin
      inst_ex     <= inst_id;
      pc_ex       <= pc_id;
      rs1_data_ex <= w_rs1_data;
      rs2_data_ex <= w_rs2_data;
      imm_ex      <= w_imm;
      rd_ex       <= w_rd;
      reg_we_ex   <= w_we;
    end
  end

endmodule
